// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port req/ack arbiter and access sequencer for the DFF RAM
// Ports: clk/rst; port A and port B each req/we/addr/wdata in, ack/rdata out;
// ram_addr/ram_wdata/ram_lr_n/ram_ce_n/ram_ena to the RAM, ram_rdata from it; busy.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_lr_n,
    output logic              ram_ce_n,
    output logic              ram_ena,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                op_we_q, op_we_d;
    logic                win_b_q, win_b_d;
    logic                last_b_q, last_b_d;
    logic                lr_n_q, lr_n_d;
    logic                ce_n_q, ce_n_d;
    logic                ena_q;
    logic                busy_q, busy_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    // A port in its ack cycle still shows req high; it must not be granted again.
    logic a_elig, b_elig, pick_b, sel_we;
    assign a_elig = a_req & ~a_ack_q;
    assign b_elig = b_req & ~b_ack_q;

    always_comb begin
        pick_b = b_elig;
        if (a_elig && b_elig) begin
            pick_b = RR ? ~last_b_q : 1'b0;
        end
        sel_we = pick_b ? b_we : a_we;
    end

    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        op_we_d     = op_we_q;
        win_b_d     = win_b_q;
        last_b_d    = last_b_q;
        lr_n_d      = 1'b1;
        ce_n_d      = 1'b1;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_elig || b_elig) begin
                    state_d     = ACC;
                    win_b_d     = pick_b;
                    last_b_d    = pick_b;
                    op_we_d     = sel_we;
                    ram_addr_d  = pick_b ? b_addr : a_addr;
                    ram_wdata_d = pick_b ? b_wdata : a_wdata;
                    // Strobes are registered, so they drop on the grant edge and cover ACC only.
                    lr_n_d      = ~sel_we;
                    ce_n_d      = sel_we;
                end
            end
            ACC: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (win_b_q) begin
                    b_ack_d = 1'b1;
                    if (!op_we_q) b_rdata_d = ram_rdata;
                end else begin
                    a_ack_d = 1'b1;
                    if (!op_we_q) a_rdata_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            op_we_q     <= 1'b0;
            win_b_q     <= 1'b0;
            last_b_q    <= 1'b1;
            lr_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            ena_q       <= 1'b0;
            busy_q      <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            op_we_q     <= op_we_d;
            win_b_q     <= win_b_d;
            last_b_q    <= last_b_d;
            lr_n_q      <= lr_n_d;
            ce_n_q      <= ce_n_d;
            ena_q       <= 1'b1;
            busy_q      <= busy_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_lr_n  = lr_n_q;
    assign ram_ce_n  = ce_n_q;
    assign ram_ena   = ena_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a RAM model and reference memory
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [3:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_ack, b_ack, ram_lr_n, ram_ce_n, ram_ena, busy;
    logic [7:0] a_rdata, b_rdata, ram_wdata;
    logic [3:0] ram_addr;
    logic [7:0] ram_rdata = 0;

    logic       f_a_req = 0, f_b_req = 0;
    logic       f_a_ack, f_b_ack, f_lr_n, f_ce_n, f_ena, f_busy;
    logic [7:0] f_a_rdata, f_b_rdata, f_wdata;
    logic [3:0] f_addr;
    logic [7:0] f_rdata = 0;

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_lr_n(ram_lr_n), .ram_ce_n(ram_ce_n),
        .ram_ena(ram_ena), .ram_rdata(ram_rdata), .busy(busy)
    );

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RR(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .a_req(f_a_req), .a_we(1'b0), .a_addr(4'd1), .a_wdata(8'd0), .a_ack(f_a_ack), .a_rdata(f_a_rdata),
        .b_req(f_b_req), .b_we(1'b0), .b_addr(4'd2), .b_wdata(8'd0), .b_ack(f_b_ack), .b_rdata(f_b_rdata),
        .ram_addr(f_addr), .ram_wdata(f_wdata), .ram_lr_n(f_lr_n), .ram_ce_n(f_ce_n),
        .ram_ena(f_ena), .ram_rdata(f_rdata), .busy(f_busy)
    );

    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        if (ram_ena) begin
            if (!ram_lr_n) mem[ram_addr] <= ram_wdata;
            if (!ram_ce_n) ram_rdata <= mem[ram_addr];
        end
        if (f_ena && !f_ce_n) f_rdata <= {4'hC, f_addr};
    end

    typedef struct {bit rd; logic [7:0] d;} exp_t;
    typedef struct {bit is_b; int cyc;} ack_t;
    exp_t exp_a[$], exp_b[$];
    ack_t ack_log[$];
    logic [7:0] ref_mem [16];
    logic [7:0] last_a = 0, last_b = 0;
    int checks = 0, failures = 0;
    int cyc = 0, lr_low = 0, ce_low = 0, b_rdata_bad = 0;
    bit loader_phase = 0;

    initial for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response whenever a port acks.
    initial begin
        exp_t e;
        logic pa, pb, plr, pce;
        pa = 0; pb = 0; plr = 0; pce = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa = 0; pb = 0; plr = 0; pce = 0;
            end else begin
                if (!ram_lr_n) begin lr_low++; chk("lr_single_cycle", {31'd0, plr}, 0); end
                if (!ram_ce_n) begin ce_low++; chk("ce_single_cycle", {31'd0, pce}, 0); end
                if (!ram_lr_n && !ram_ce_n) chk("both_strobes_low", 1, 0);
                if (loader_phase && b_rdata != 8'h00) b_rdata_bad++;
                if (a_ack) begin
                    chk("a_ack_pulse", {31'd0, pa}, 0);
                    ack_log.push_back('{is_b: 1'b0, cyc: cyc});
                    if (exp_a.size() == 0) chk("a_unexpected_ack", 1, 0);
                    else begin e = exp_a.pop_front(); chk(e.rd ? "a_rdata" : "a_rdata_hold", a_rdata, e.d); end
                end
                if (b_ack) begin
                    chk("b_ack_pulse", {31'd0, pb}, 0);
                    ack_log.push_back('{is_b: 1'b1, cyc: cyc});
                    if (exp_b.size() == 0) chk("b_unexpected_ack", 1, 0);
                    else begin e = exp_b.pop_front(); chk(e.rd ? "b_rdata" : "b_rdata_hold", b_rdata, e.d); end
                end
                pa = a_ack; pb = b_ack; plr = !ram_lr_n; pce = !ram_ce_n;
            end
        end
    end

    // Issues one access and pushes its expected response; returns cycles from eligibility to ack.
    task automatic txn(input bit is_b, input bit we, input logic [3:0] addr, input logic [7:0] d,
                       input bit keep, output int lat);
        exp_t e;
        e.rd = !we;
        if (we) begin
            ref_mem[addr] = d;
            e.d = is_b ? last_b : last_a;
        end else begin
            e.d = ref_mem[addr];
            if (is_b) last_b = e.d; else last_a = e.d;
        end
        if (is_b) begin
            exp_b.push_back(e); b_we = we; b_addr = addr; b_wdata = d; b_req = 1;
        end else begin
            exp_a.push_back(e); a_we = we; a_addr = addr; a_wdata = d; a_req = 1;
        end
        lat = 0;
        @(negedge clk);
        while (!(is_b ? b_ack : a_ack) && lat < 60) begin lat++; @(negedge clk); end
        if (!(is_b ? b_ack : a_ack)) chk(is_b ? "b_ack_timeout" : "a_ack_timeout", 0, 1);
        if (!keep) begin
            @(posedge clk); #1;
            if (is_b) b_req = 0; else a_req = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1; a_req = 0; b_req = 0; f_a_req = 0; f_b_req = 0;
        last_a = 0; last_b = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic f_wait(input bit want_b, output int n);
        n = 0;
        @(negedge clk);
        while (!(want_b ? f_b_ack : f_a_ack) && n < 40) begin n++; @(negedge clk); end
        if (!(want_b ? f_b_ack : f_a_ack)) chk("fp_ack_timeout", 0, 1);
    endtask

    int lat, l0, c0, n;

    initial begin
        #12;
        chk("rst_strobes", {26'd0, ram_lr_n, ram_ce_n, ram_ena, busy, a_ack, b_ack}, 32'b110000);
        chk("rst_addr_wdata", {20'd0, ram_addr, ram_wdata}, 0);
        chk("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        chk("ram_ena_after_rst", {31'd0, ram_ena}, 1);

        // Write then read addr 5.
        l0 = lr_low; c0 = ce_low;
        txn(0, 1, 4'd5, 8'hA5, 0, lat);
        chk("wr_latency", lat, 3);
        chk("wr_lr_cycles", lr_low - l0, 1);
        chk("wr_ce_cycles", ce_low - c0, 0);
        l0 = lr_low; c0 = ce_low;
        txn(0, 0, 4'd5, 8'h00, 0, lat);
        chk("rd_latency", lat, 3);
        chk("rd_ce_cycles", ce_low - c0, 1);
        chk("rd_lr_cycles", lr_low - l0, 0);

        // Round-robin tie from reset: A first, strict alternation, one ack per 3 cycles.
        do_reset();
        ack_log.delete();
        fork
            for (int i = 0; i < 4; i++) begin int la; txn(0, 0, 4'(i), 8'h00, i < 3, la); end
            for (int i = 0; i < 4; i++) begin int lb; txn(1, 0, 4'(i + 8), 8'h00, i < 3, lb); end
        join
        repeat (4) @(posedge clk); #1;
        chk("rr_ack_count", ack_log.size(), 8);
        for (int k = 0; k < ack_log.size(); k++) begin
            chk("rr_order", {31'd0, ack_log[k].is_b}, k % 2);
            if (k > 0) chk("rr_spacing", ack_log[k].cyc - ack_log[k-1].cyc, 3);
        end

        // Held req with the other port idle: re-grant only after the ack cycle.
        ack_log.delete();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            txn(0, 0, 4'(i + 4), 8'h00, i < 3, lat);
            chk("hold_latency", lat, 3);
        end
        chk("hold_ack_count", ack_log.size(), 4);
        for (int k = 1; k < ack_log.size(); k++)
            chk("hold_spacing", ack_log[k].cyc - ack_log[k-1].cyc, 4);

        // Pointer now says A was last: a fresh tie goes to B under round-robin.
        ack_log.delete();
        fork
            begin int la; txn(0, 0, 4'd2, 8'h00, 0, la); end
            begin int lb; txn(1, 0, 4'd9, 8'h00, 0, lb); end
        join
        chk("rr_tie_after_a_count", ack_log.size(), 2);
        if (ack_log.size() == 2) chk("rr_tie_after_a_first_b", {31'd0, ack_log[0].is_b}, 1);

        // Fixed priority: after an A access, a fresh tie still goes to A; B follows 3 cycles after A's ack.
        @(posedge clk); #1 f_a_req = 1;
        f_wait(0, n);
        @(posedge clk); #1 f_a_req = 0;
        repeat (2) @(posedge clk); #1 begin f_a_req = 1; f_b_req = 1; end
        f_wait(0, n);
        chk("fp_tie_a_latency", n, 3);
        chk("fp_tie_b_not_first", {31'd0, f_b_ack}, 0);
        chk("fp_rdata_a", f_a_rdata, 8'hC1);
        @(posedge clk); #1 f_a_req = 0;
        f_wait(1, n);
        chk("fp_b_after_a_drop", n, 2);
        chk("fp_rdata_b", f_b_rdata, 8'hC2);
        @(posedge clk); #1 f_b_req = 0;

        // Loader writes all 16, then CPU reads them back.
        do_reset();
        loader_phase = 1;
        for (int i = 0; i < 16; i++) txn(1, 1, 4'(i), 8'(i + 1), 0, lat);
        for (int i = 0; i < 16; i++) txn(0, 0, 4'(i), 8'h00, 0, lat);
        loader_phase = 0;
        chk("loader_b_rdata_zero", b_rdata_bad, 0);
        chk("loader_a_last_read", a_rdata, 8'h10);

        // Random traffic on disjoint halves of the RAM.
        fork
            for (int i = 0; i < 20; i++) begin
                int la;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 txn(0, 1'($urandom), 4'($urandom_range(0, 7)), 8'($urandom), 0, la);
            end
            for (int i = 0; i < 20; i++) begin
                int lb;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 txn(1, 1'($urandom), 4'($urandom_range(8, 15)), 8'($urandom), 0, lb);
            end
        join
        repeat (6) @(posedge clk); #1;
        chk("rand_queues_drained", exp_a.size() + exp_b.size(), 0);

        // Reset during ACC of an A read: immediate return to reset values, no ack ever.
        ack_log.delete();
        a_we = 0; a_addr = 4'd3; a_req = 1;
        n = 0;
        @(negedge clk);
        while (ram_ce_n && n < 10) begin n++; @(negedge clk); end
        chk("abort_reached_acc", {31'd0, ram_ce_n}, 0);
        #2 rst = 1; a_req = 0;
        #1;
        chk("abort_ce_n", {31'd0, ram_ce_n}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_a_ack", {31'd0, a_ack}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk); #1;
        chk("abort_no_ack", ack_log.size(), 0);

        chk("final_queues_empty", exp_a.size() + exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
